// File: rtl/decoder_n_seq.sv
// Registered N-to-2**N one-hot decoder with optional auto-scan mode.
// Define DECODER_N_SEQ_SCAN_EN to build the SCAN state, dwell counter and wrap pulse.
module decoder_n_seq #(
    parameter int N     = 3,
    parameter int DWELL = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            E,
    input  logic [N-1:0]    A,
    input  logic            mode,
    output logic [2**N-1:0] Y,
    output logic [N-1:0]    idx,
    output logic            wrap
);

    localparam int YW = 2**N;

    typedef enum logic [1:0] {
        IDLE,
        DIRECT,
        SCAN
    } state_t;

    state_t          state_q, state_d;
    logic [YW-1:0]   y_d;
    logic [N-1:0]    idx_d;
    logic            wrap_d;
    logic            scan_req;

`ifdef DECODER_N_SEQ_SCAN_EN
    localparam int            CW       = (DWELL > 1) ? $clog2(DWELL) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DWELL - 1);

    logic [CW-1:0] cnt_q, cnt_d;

    assign scan_req = mode;
`else
    // Without scan support the mode input and dwell setting have no effect.
    logic [8:0] unused_cfg;

    assign scan_req   = 1'b0;
    assign unused_cfg = {mode, 8'(DWELL)};
`endif

    function automatic logic [YW-1:0] one_hot(input logic [N-1:0] i);
        return YW'(1) << i;
    endfunction

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        state_d = state_q;
        idx_d   = idx;
        y_d     = '0;
        wrap_d  = 1'b0;
`ifdef DECODER_N_SEQ_SCAN_EN
        cnt_d   = '0;
`endif
        if (E) begin
            state_d = IDLE;
        end else if (!scan_req) begin
            state_d = DIRECT;
            idx_d   = A;
            y_d     = one_hot(A);
        end
`ifdef DECODER_N_SEQ_SCAN_EN
        else if (state_q != SCAN) begin
            state_d = SCAN;
            idx_d   = A;
            y_d     = one_hot(A);
        end else begin
            // A is not consulted while scanning; only the dwell counter moves idx.
            if (cnt_q == CNT_LAST) begin
                idx_d  = idx + 1'b1;
                wrap_d = (idx == {N{1'b1}});
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
            y_d = one_hot(idx_d);
        end
`endif
    end

    // NOTE: state registers use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            Y       <= '0;
            idx     <= '0;
            wrap    <= 1'b0;
`ifdef DECODER_N_SEQ_SCAN_EN
            cnt_q   <= '0;
`endif
        end else begin
            state_q <= state_d;
            Y       <= y_d;
            idx     <= idx_d;
            wrap    <= wrap_d;
`ifdef DECODER_N_SEQ_SCAN_EN
            cnt_q   <= cnt_d;
`endif
        end
    end

endmodule

// File: tb/tb_decoder_n_seq.sv
// Directed self-checking bench for decoder_n_seq with N=3, DWELL=2.
// Scan-mode sequences run only when DECODER_N_SEQ_SCAN_EN is defined.
module tb_decoder_n_seq;

    localparam int N     = 3;
    localparam int DWELL = 2;

    logic         clk = 1'b0;
    logic         rst_n;
    logic         E;
    logic [N-1:0] A;
    logic         mode;
    logic [7:0]   Y;
    logic [N-1:0] idx;
    logic         wrap;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        logic         e;
        logic         mode;
        logic [N-1:0] a;
        logic [7:0]   y;
        logic [N-1:0] idx;
        logic         wrap;
    } vec_t;

    vec_t vecs[$];

    decoder_n_seq #(.N(N), .DWELL(DWELL)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .E    (E),
        .A    (A),
        .mode (mode),
        .Y    (Y),
        .idx  (idx),
        .wrap (wrap)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic check_out(input string name, input logic [7:0] y_e,
                             input logic [N-1:0] idx_e, input logic wrap_e);
        check({name, ".Y"}, 64'(Y), 64'(y_e));
        check({name, ".idx"}, 64'(idx), 64'(idx_e));
        check({name, ".wrap"}, 64'(wrap), 64'(wrap_e));
    endtask

    initial begin
        logic [7:0] scan_y[7];
        logic       scan_w[7];
        logic [N-1:0] scan_i[7];

        // Reset held with the clock running and enabled inputs present.
        rst_n = 1'b0;
        E     = 1'b0;
        mode  = 1'b0;
        A     = 3'd5;
        #1;
        check_out("reset_t0", 8'h00, 3'd0, 1'b0);
        for (int i = 0; i < 3; i++) begin
            step();
            check_out("reset_clk", 8'h00, 3'd0, 1'b0);
        end
        rst_n = 1'b1;

        // Disabled sweep, enabled direct sweep, then disable again from idx 7.
        for (int a = 0; a < 8; a++)
            vecs.push_back('{e: 1'b1, mode: 1'b0, a: 3'(a), y: 8'h00, idx: 3'd0, wrap: 1'b0});
        for (int a = 0; a < 8; a++)
            vecs.push_back('{e: 1'b0, mode: 1'b0, a: 3'(a), y: 8'(1 << a), idx: 3'(a), wrap: 1'b0});
        vecs.push_back('{e: 1'b1, mode: 1'b0, a: 3'd3, y: 8'h00, idx: 3'd7, wrap: 1'b0});
        vecs.push_back('{e: 1'b0, mode: 1'b0, a: 3'd2, y: 8'h04, idx: 3'd2, wrap: 1'b0});
        vecs.push_back('{e: 1'b1, mode: 1'b1, a: 3'd6, y: 8'h00, idx: 3'd2, wrap: 1'b0});

        foreach (vecs[i]) begin
            E    = vecs[i].e;
            mode = vecs[i].mode;
            A    = vecs[i].a;
            step();
            check_out($sformatf("vec%0d", i), vecs[i].y, vecs[i].idx, vecs[i].wrap);
            check($sformatf("vec%0d.onehot", i), 64'($countones(Y) <= 1), 64'(1));
        end

`ifdef DECODER_N_SEQ_SCAN_EN
        // Scan from 6 with dwell 2: 6,6,7,7,0(wrap),0,1. A changes after entry and is ignored.
        scan_y = '{8'h40, 8'h40, 8'h80, 8'h80, 8'h01, 8'h01, 8'h02};
        scan_i = '{3'd6, 3'd6, 3'd7, 3'd7, 3'd0, 3'd0, 3'd1};
        scan_w = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
        E    = 1'b0;
        mode = 1'b1;
        A    = 3'd6;
        for (int i = 0; i < 7; i++) begin
            step();
            A = 3'd2;
            check_out($sformatf("scan%0d", i), scan_y[i], scan_i[i], scan_w[i]);
        end

        // Enter scan at idx 3 via DIRECT, then disable with mode toggling on the same edge.
        mode = 1'b0;
        A    = 3'd3;
        step();
        check_out("direct3", 8'h08, 3'd3, 1'b0);
        mode = 1'b1;
        step();
        check_out("scan3_enter", 8'h08, 3'd3, 1'b0);
        step();
        check_out("scan3_dwell", 8'h08, 3'd3, 1'b0);
        E    = 1'b1;
        mode = 1'b0;
        step();
        check_out("scan3_disable", 8'h00, 3'd3, 1'b0);

        // Re-entry from IDLE reloads idx from A.
        E    = 1'b0;
        mode = 1'b1;
        A    = 3'd1;
        step();
        check_out("rescan1", 8'h02, 3'd1, 1'b0);
        step();
        check_out("rescan1_dwell", 8'h02, 3'd1, 1'b0);
        step();
        check_out("rescan2", 8'h04, 3'd2, 1'b0);

        // Drop to direct mid-scan.
        mode = 1'b0;
        A    = 3'd4;
        step();
        check_out("scan_to_direct", 8'h10, 3'd4, 1'b0);

        // Scan at idx 7 one edge before a wrap, then reset asynchronously.
        mode = 1'b1;
        A    = 3'd7;
        step();
        check_out("scan7_enter", 8'h80, 3'd7, 1'b0);
        step();
        check_out("scan7_dwell", 8'h80, 3'd7, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check_out("async_reset", 8'h00, 3'd0, 1'b0);
        step();
        check_out("reset_no_wrap", 8'h00, 3'd0, 1'b0);
        A = 3'd5;
        #2;
        rst_n = 1'b1;
        #1;
        check_out("release_hold", 8'h00, 3'd0, 1'b0);
        step();
        check_out("post_reset_scan", 8'h20, 3'd5, 1'b0);
`else
        // Registered direct decoder only: mode is ignored and wrap never pulses.
        E    = 1'b0;
        mode = 1'b1;
        A    = 3'd2;
        for (int i = 0; i < 6; i++) begin
            step();
            check_out($sformatf("noscan%0d", i), 8'h04, 3'd2, 1'b0);
        end
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/decoder_n_seq.md
DECODER_N_SEQ -- requirements
Module: decoder_n_seq

Interface
REQ-001 Parameter: N, default 3, address width; output width is 2**N; legal range 1..6.
REQ-002 Parameter: DWELL, default 1, clock cycles each output stays asserted in scan mode; legal range 1..255.
REQ-003 Port: clk  input  1  single clock; all state updates on its rising edge.
REQ-004 Port: rst_n  input  1  asynchronous active-low reset.
REQ-005 Port: E  input  1  active-low enable (0 = enabled, 1 = disabled).
REQ-006 Port: A  input  N  address; direct-mode select and scan start index.
REQ-007 Port: mode  input  1  0 = direct decode, 1 = auto-scan.
REQ-008 Port: Y  output  2**N  registered one-hot decode output.
REQ-009 Port: idx  output  N  registered index currently driven on Y.
REQ-010 Port: wrap  output  1  one-cycle pulse when the scan index wraps from 2**N-1 to 0.

Function
REQ-011 Three states: IDLE, DIRECT, SCAN; all outputs are registered.
REQ-012 E=1 on any edge -> next state IDLE; Y=0, wrap=0, idx holds its value.
REQ-013 E=0, mode=0 -> next state DIRECT; Y = one-hot(A), idx = A, one-cycle latency from A to Y.
REQ-014 E=0, mode=1 from IDLE or DIRECT -> next state SCAN; idx loaded from A, Y = one-hot(A), dwell counter cleared.
REQ-015 In SCAN, the dwell counter counts 0..DWELL-1; on the edge where it reaches DWELL-1, idx increments by 1 modulo 2**N and the counter clears.
REQ-016 In SCAN, A is ignored after entry; re-entry through IDLE or DIRECT reloads idx from A.
REQ-017 wrap=1 for exactly the cycle in which idx has just advanced from 2**N-1 to 0; otherwise wrap=0.
REQ-018 DWELL=1 -> idx advances on every clock in SCAN, giving a walking one-hot at clock rate.
REQ-019 mode 1->0 mid-scan -> next cycle is DIRECT with Y = one-hot(A), and the dwell count is discarded.
REQ-020 E and mode changes on the same edge: E has priority.
REQ-021 Y always has zero or one bit set; Y is never a multi-hot value.

Reset
REQ-022 On rst_n=0, immediately and independent of clk: state = IDLE, Y = 0, idx = 0, wrap = 0, dwell counter = 0.
REQ-023 On rst_n release, first update occurs at the next rising clk edge; reset asserted mid-scan aborts the scan with no wrap pulse.

Configuration
REQ-024 Macro DECODER_N_SEQ_SCAN_EN: when defined, SCAN state, dwell counter and wrap logic are compiled in as specified above.
REQ-025 Without DECODER_N_SEQ_SCAN_EN: mode input is ignored and treated as 0, wrap is tied to 0, and the block is a registered direct decoder only.

Verification (N=3, DWELL=2, DECODER_N_SEQ_SCAN_EN defined unless noted)
REQ-026 rst_n=0 with clock toggling, E=0, A=5 -> Y=00000000, idx=0, wrap=0 throughout reset.
REQ-027 E=1, A=0..7 -> Y=00000000 every cycle; then E=0, mode=0, A stepping 0..7 one per clock -> Y=00000001..10000000 one cycle behind A.
REQ-028 E=0, mode=1, A=6 -> Y=01000000 for 2 cycles, 10000000 for 2 cycles, 00000001 with wrap=1 for one cycle only, then 00000010.
REQ-029 Mid-scan with idx=3, E=1 -> Y=0 next cycle, idx holds 3; E=0 with A=1 -> scan restarts with Y=00000010.
REQ-030 Mid-scan, mode=0 with A=4 -> next cycle Y=00010000; assert rst_n=0 mid-scan -> Y=0 immediately with no wrap.
REQ-031 Macro undefined, mode=1, A=2 -> Y=00000100 held steady and wrap stays 0.
